// File: rtl/btb_assoc_pkg.sv
// Shared types, encodings and counter helpers for the set-associative BTB.
package btb_assoc_pkg;

  localparam int XLEN     = 32;
  localparam int BTB_SETS = 16;
  localparam int BTB_WAYS = 2;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } flush_state_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup, EX-side update and flush signals of the BTB.
interface btb_assoc_if #(
  parameter int XLEN = btb_assoc_pkg::XLEN
);
  logic [XLEN-1:0] pc_if;
  logic            lookup_enable;
  logic            hit_valid;
  logic            predict_taken;
  logic [XLEN-1:0] target_predict;
  logic [XLEN-1:0] pc_hit;
  logic            update_enable;
  logic [XLEN-1:0] pc_update;
  logic [XLEN-1:0] target_update;
  logic            update_taken;
  logic            update_is_jump;
  logic            flush;
  logic            flush_busy;

  modport master (
    output pc_if, lookup_enable, update_enable, pc_update, target_update,
           update_taken, update_is_jump, flush,
    input  hit_valid, predict_taken, target_predict, pc_hit, flush_busy
  );

  modport slave (
    input  pc_if, lookup_enable, update_enable, pc_update, target_update,
           update_taken, update_is_jump, flush,
    output hit_valid, predict_taken, target_predict, pc_hit, flush_busy
  );
endinterface

// File: rtl/btb_assoc_victim_sel.sv
// Allocation victim: lowest-index invalid way, otherwise the set's round-robin pointer.
module btb_assoc_victim_sel #(
  parameter int N_WAYS = 2,
  parameter int WAY_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
  input  logic [N_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]  rr_ptr_i,
  output logic [WAY_W-1:0]  way_o,
  output logic              use_rr_o
);

  always_comb begin
    way_o    = rr_ptr_i;
    use_rr_o = 1'b1;
    // Descending scan so the lowest invalid way is the one that sticks.
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        way_o    = WAY_W'(w);
        use_rr_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with 2-bit direction counters, combinational lookup and a per-set flush sweep.
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int         N_SETS   = BTB_SETS,
  parameter int         N_WAYS   = BTB_WAYS,
  parameter logic [1:0] CTR_INIT = CTR_WT
) (
  input logic        clk,
  input logic        reset,
  btb_assoc_if.slave bus
);

  localparam int IDX_W = $clog2(N_SETS);
  localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [N_WAYS-1:0] valid_q [N_SETS];
  logic [TAG_W-1:0]  tag_q   [N_SETS][N_WAYS];
  logic [XLEN-1:0]   tgt_q   [N_SETS][N_WAYS];
  logic [1:0]        ctr_q   [N_SETS][N_WAYS];
  logic [WAY_W-1:0]  rr_q    [N_SETS];

  flush_state_e      state_q, state_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;
  logic              clr_en;

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_match, up_hit;
  logic [WAY_W-1:0]  lk_way, up_way, vic_way;
  logic              vic_rr;
  logic              upd_ok, lk_hit;
  logic              unused_pc_lsb;

  assign lk_idx = bus.pc_if[IDX_W+1:2];
  assign lk_tag = bus.pc_if[XLEN-1:IDX_W+2];
  assign up_idx = bus.pc_update[IDX_W+1:2];
  assign up_tag = bus.pc_update[XLEN-1:IDX_W+2];
  assign unused_pc_lsb = ^{bus.pc_if[1:0], bus.pc_update[1:0]};

  always_comb begin
    lk_match = 1'b0;
    lk_way   = '0;
    up_hit   = 1'b0;
    up_way   = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_match = 1'b1;
        lk_way   = WAY_W'(w);
      end
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
    end
  end

  assign lk_hit             = bus.lookup_enable && (state_q == ST_IDLE) && lk_match;
  assign bus.hit_valid      = lk_hit;
  assign bus.predict_taken  = lk_hit && ctr_q[lk_idx][lk_way][1];
  assign bus.target_predict = lk_hit ? tgt_q[lk_idx][lk_way] : bus.pc_if + XLEN'(4);
  assign bus.pc_hit         = lk_hit ? bus.pc_if : '0;
  assign bus.flush_busy     = (state_q == ST_SWEEP);

  btb_assoc_victim_sel #(
    .N_WAYS (N_WAYS),
    .WAY_W  (WAY_W)
  ) u_victim_sel (
    .valid_i  (valid_q[up_idx]),
    .rr_ptr_i (rr_q[up_idx]),
    .way_o    (vic_way),
    .use_rr_o (vic_rr)
  );

  assign upd_ok = bus.update_enable && (state_q == ST_IDLE) && !bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          state_d = ST_SWEEP;
          sweep_d = '0;
        end
      end
      ST_SWEEP: begin
        clr_en  = 1'b1;
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(N_SETS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sweep and update never coincide: updates are only accepted in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < N_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < N_WAYS; w++) begin
          tag_q[s][w] <= '0;
          tgt_q[s][w] <= '0;
          ctr_q[s][w] <= CTR_SNT;
        end
      end
    end else begin
      if (clr_en) begin
        valid_q[sweep_q] <= '0;
      end
      if (upd_ok) begin
        if (up_hit) begin
          if (bus.update_is_jump) begin
            tgt_q[up_idx][up_way] <= bus.target_update;
            ctr_q[up_idx][up_way] <= CTR_ST;
          end else if (bus.update_taken) begin
            tgt_q[up_idx][up_way] <= bus.target_update;
            ctr_q[up_idx][up_way] <= sat_inc(ctr_q[up_idx][up_way]);
          end else begin
            ctr_q[up_idx][up_way] <= sat_dec(ctr_q[up_idx][up_way]);
          end
        end else if (bus.update_taken || bus.update_is_jump) begin
          valid_q[up_idx][vic_way] <= 1'b1;
          tag_q[up_idx][vic_way]   <= up_tag;
          tgt_q[up_idx][vic_way]   <= bus.target_update;
          ctr_q[up_idx][vic_way]   <= bus.update_is_jump ? CTR_ST : CTR_INIT;
          if (vic_rr) begin
            rr_q[up_idx] <= (rr_q[up_idx] == WAY_W'(N_WAYS - 1)) ? '0
                                                                 : rr_q[up_idx] + WAY_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc (16 sets, 2 ways, XLEN 32).
module tb_btb_assoc;
  import btb_assoc_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  btb_assoc_if #(.XLEN(32)) bus ();

  btb_assoc #(
    .N_SETS   (16),
    .N_WAYS   (2),
    .CTR_INIT (2'b10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.update_enable  = 1'b0;
    bus.pc_update      = '0;
    bus.target_update  = '0;
    bus.update_taken   = 1'b0;
    bus.update_is_jump = 1'b0;
    bus.flush          = 1'b0;
  endtask

  // Holds an update for one clock edge, then removes it.
  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic taken, input logic jump);
    bus.update_enable  = 1'b1;
    bus.pc_update      = pc;
    bus.target_update  = tgt;
    bus.update_taken   = taken;
    bus.update_is_jump = jump;
    next_cycle();
    idle_inputs();
  endtask

  task automatic look(input logic [31:0] pc);
    bus.pc_if         = pc;
    bus.lookup_enable = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    look(32'h100);
    repeat (3) next_cycle();
    reset = 1'b0;
    next_cycle();
    look(32'h100);
    n_checks += 5;
    if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hit got %0b want 0", bus.hit_valid); end
    if (bus.predict_taken !== 1'b0) begin n_errors++; $display("FAIL reset_taken got %0b want 0", bus.predict_taken); end
    if (bus.target_predict !== 32'h104) begin n_errors++; $display("FAIL reset_target got %h want 00000104", bus.target_predict); end
    if (bus.pc_hit !== 32'h0) begin n_errors++; $display("FAIL reset_pc_hit got %h want 0", bus.pc_hit); end
    if (bus.flush_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b want 0", bus.flush_busy); end
  endtask

  task automatic test_alloc();
    bus.update_enable = 1'b1;
    bus.pc_update     = 32'h100;
    bus.target_update = 32'h400;
    bus.update_taken  = 1'b1;
    look(32'h100);
    n_checks++;
    if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL same_cycle_hit got %0b want 0", bus.hit_valid); end
    next_cycle();
    idle_inputs();
    look(32'h100);
    n_checks += 4;
    if (bus.hit_valid !== 1'b1) begin n_errors++; $display("FAIL alloc_hit got %0b want 1", bus.hit_valid); end
    if (bus.predict_taken !== 1'b1) begin n_errors++; $display("FAIL alloc_taken got %0b want 1", bus.predict_taken); end
    if (bus.target_predict !== 32'h400) begin n_errors++; $display("FAIL alloc_target got %h want 00000400", bus.target_predict); end
    if (bus.pc_hit !== 32'h100) begin n_errors++; $display("FAIL alloc_pc_hit got %h want 00000100", bus.pc_hit); end
    bus.lookup_enable = 1'b0;
    #1;
    n_checks += 2;
    if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL lookup_disabled_hit got %0b want 0", bus.hit_valid); end
    if (bus.target_predict !== 32'h104) begin n_errors++; $display("FAIL lookup_disabled_target got %h want 00000104", bus.target_predict); end
  endtask

  task automatic test_counter();
    do_update(32'h100, 32'h0, 1'b0, 1'b0);
    do_update(32'h100, 32'h0, 1'b0, 1'b0);
    look(32'h100);
    n_checks += 3;
    if (bus.hit_valid !== 1'b1) begin n_errors++; $display("FAIL nt_hit got %0b want 1", bus.hit_valid); end
    if (bus.predict_taken !== 1'b0) begin n_errors++; $display("FAIL nt_taken got %0b want 0", bus.predict_taken); end
    if (bus.target_predict !== 32'h400) begin n_errors++; $display("FAIL nt_target got %h want 00000400", bus.target_predict); end
    // Saturated at 0: one taken brings it to 1 (still not-taken), a second to 2.
    do_update(32'h100, 32'h0, 1'b0, 1'b0);
    do_update(32'h100, 32'h480, 1'b1, 1'b0);
    look(32'h100);
    n_checks += 2;
    if (bus.predict_taken !== 1'b0) begin n_errors++; $display("FAIL sat_dec_taken got %0b want 0", bus.predict_taken); end
    if (bus.target_predict !== 32'h480) begin n_errors++; $display("FAIL taken_target got %h want 00000480", bus.target_predict); end
    do_update(32'h100, 32'h480, 1'b1, 1'b0);
    look(32'h100);
    n_checks++;
    if (bus.predict_taken !== 1'b1) begin n_errors++; $display("FAIL inc_taken got %0b want 1", bus.predict_taken); end
  endtask

  task automatic test_eviction();
    do_update(32'h140, 32'h500, 1'b1, 1'b0);
    do_update(32'h180, 32'h600, 1'b1, 1'b0);
    look(32'h100);
    n_checks++;
    if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL evict_100_hit got %0b want 0", bus.hit_valid); end
    look(32'h140);
    n_checks += 2;
    if (bus.hit_valid !== 1'b1) begin n_errors++; $display("FAIL keep_140_hit got %0b want 1", bus.hit_valid); end
    if (bus.target_predict !== 32'h500) begin n_errors++; $display("FAIL keep_140_target got %h want 00000500", bus.target_predict); end
    look(32'h180);
    n_checks += 2;
    if (bus.hit_valid !== 1'b1) begin n_errors++; $display("FAIL new_180_hit got %0b want 1", bus.hit_valid); end
    if (bus.target_predict !== 32'h600) begin n_errors++; $display("FAIL new_180_target got %h want 00000600", bus.target_predict); end
    // Round-robin pointer advanced to way1, so 0x1C0 displaces 0x140.
    do_update(32'h1C0, 32'h700, 1'b1, 1'b0);
    look(32'h140);
    n_checks++;
    if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL evict_140_hit got %0b want 0", bus.hit_valid); end
    look(32'h180);
    n_checks++;
    if (bus.hit_valid !== 1'b1) begin n_errors++; $display("FAIL keep_180_hit got %0b want 1", bus.hit_valid); end
    do_update(32'h104, 32'h0, 1'b0, 1'b0);
    look(32'h104);
    n_checks++;
    if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL nt_miss_alloc got %0b want 0", bus.hit_valid); end
  endtask

  task automatic test_back_to_back();
    do_update(32'h308, 32'hA00, 1'b1, 1'b0);
    do_update(32'h30C, 32'hB00, 1'b1, 1'b0);
    do_update(32'h03C, 32'h900, 1'b1, 1'b0);
    look(32'h308);
    n_checks += 2;
    if (bus.hit_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_308_hit got %0b want 1", bus.hit_valid); end
    if (bus.target_predict !== 32'hA00) begin n_errors++; $display("FAIL b2b_308_target got %h want 00000a00", bus.target_predict); end
    look(32'h30C);
    n_checks += 2;
    if (bus.hit_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_30c_hit got %0b want 1", bus.hit_valid); end
    if (bus.target_predict !== 32'hB00) begin n_errors++; $display("FAIL b2b_30c_target got %h want 00000b00", bus.target_predict); end
  endtask

  task automatic test_flush();
    int busy_cycles;
    int waited;
    logic [31:0] pcs [6];
    pcs = '{32'h180, 32'h1C0, 32'h03C, 32'h308, 32'h204, 32'h244};
    bus.flush         = 1'b1;
    bus.update_enable = 1'b1;
    bus.pc_update     = 32'h204;
    bus.target_update = 32'hC00;
    bus.update_taken  = 1'b1;
    next_cycle();
    idle_inputs();
    busy_cycles = 0;
    waited      = 0;
    look(32'h180);
    while (bus.flush_busy === 1'b1 && waited < 40) begin
      busy_cycles++;
      n_checks++;
      if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL sweep_hit cycle %0d got %0b want 0", busy_cycles, bus.hit_valid); end
      if (busy_cycles == 5) begin
        bus.flush         = 1'b1;
        bus.update_enable = 1'b1;
        bus.pc_update     = 32'h244;
        bus.target_update = 32'hD00;
        bus.update_taken  = 1'b1;
      end
      next_cycle();
      idle_inputs();
      look(32'h180);
      waited++;
    end
    n_checks++;
    if (busy_cycles != 16) begin n_errors++; $display("FAIL sweep_length got %0d want 16", busy_cycles); end
    for (int i = 0; i < 6; i++) begin
      look(pcs[i]);
      n_checks++;
      if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL post_flush_hit pc %h got %0b want 0", pcs[i], bus.hit_valid); end
    end
  endtask

  task automatic test_jump_reset();
    do_update(32'h200, 32'h800, 1'b0, 1'b1);
    do_update(32'h200, 32'h0, 1'b0, 1'b0);
    look(32'h200);
    n_checks += 4;
    if (bus.hit_valid !== 1'b1) begin n_errors++; $display("FAIL jump_hit got %0b want 1", bus.hit_valid); end
    if (bus.predict_taken !== 1'b1) begin n_errors++; $display("FAIL jump_taken got %0b want 1", bus.predict_taken); end
    if (bus.target_predict !== 32'h800) begin n_errors++; $display("FAIL jump_target got %h want 00000800", bus.target_predict); end
    if (bus.pc_hit !== 32'h200) begin n_errors++; $display("FAIL jump_pc_hit got %h want 00000200", bus.pc_hit); end
    // Set 15 entry would survive if the sweep were only partly done.
    do_update(32'h03C, 32'h900, 1'b1, 1'b0);
    bus.flush = 1'b1;
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
    n_checks++;
    if (bus.flush_busy !== 1'b1) begin n_errors++; $display("FAIL mid_sweep_busy got %0b want 1", bus.flush_busy); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.flush_busy !== 1'b0) begin n_errors++; $display("FAIL async_reset_busy got %0b want 0", bus.flush_busy); end
    next_cycle();
    reset = 1'b0;
    next_cycle();
    look(32'h200);
    n_checks++;
    if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_200_hit got %0b want 0", bus.hit_valid); end
    look(32'h03C);
    n_checks += 2;
    if (bus.hit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_03c_hit got %0b want 0", bus.hit_valid); end
    if (bus.target_predict !== 32'h40) begin n_errors++; $display("FAIL reset_03c_target got %h want 00000040", bus.target_predict); end
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    reset             = 1'b1;
    bus.pc_if         = '0;
    bus.lookup_enable = 1'b0;
    idle_inputs();
    test_reset();
    test_alloc();
    test_counter();
    test_eviction();
    test_back_to_back();
    test_flush();
    test_jump_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
